uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter sharing the single UART transmitter among four byte-stream requesters (memory dump sender, echo path, status reporter, debug). It sits between the requesters and the transmitter's `transmitter_start`/`tx_ready` handshake. It grants the transmitter for a whole packet, forwards one byte per transmitter cycle, and acknowledges each byte to its owner. A watchdog flags a transmitter that never accepts a start.

## Interface
- `BUSY_TIMEOUT`, 16: cycles allowed for `tx_ready` to fall after `transmitter_start` rises; range 2..65535.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  4  bit i: requester i has a valid byte on its data lane.
- `req_data`  in  32  byte for requester i on bits [8i+7:8i].
- `req_last`  in  4  bit i: requester i's current byte ends its packet.
- `clr_err`  in  1  synchronous clear of `timeout_err`.
- `tx_ready`  in  1  transmitter idle (high) / busy (low).
- `grant`  out  4  one-hot owner of the transmitter; 0 when idle.
- `ack`  out  4  one-cycle pulse: requester i's byte latched; requester presents its next byte or drops `req` on the following cycle.
- `transmitter_data`  out  8  registered byte to the transmitter.
- `transmitter_start`  out  1  start level to the transmitter.
- `busy`  out  1  high whenever the state is not IDLE.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- Reset values: `grant`=0, `ack`=0, `transmitter_data`=0x00, `transmitter_start`=0, `busy`=0, `timeout_err`=0, state IDLE, round-robin pointer `ptr`=3, so requester 0 has first priority.
- States: IDLE, GRANTED, WAIT_BUSY, WAIT_DONE.
- **IDLE:**
  - If `tx_ready`=1 and `req`≠0, grant the first requesting index in order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Set `grant` one-hot and go to GRANTED.
  - If `tx_ready`=0, stay in IDLE.
- **GRANTED (owner g):**
  - If `req[g]`=1 and `tx_ready`=1: `transmitter_data`<=byte g, `transmitter_start`<=1, `ack[g]`<=1 for one cycle, `last_q`<=`req_last[g]`, clear the watchdog counter, go to WAIT_BUSY.
  - If `req[g]`=0: hold `grant` (packet lock); other requesters are never served mid-packet.
- **WAIT_BUSY:**
  - `transmitter_start` stays 1 until `tx_ready`=0; then `transmitter_start`<=0 and go to WAIT_DONE.
  - If the counter reaches BUSY_TIMEOUT-1 with `tx_ready` still 1: `transmitter_start`<=0, `timeout_err`<=1, `grant`<=0, `ptr`<=g, go to IDLE. The packet is abandoned and no further `ack` is issued for it.
- **WAIT_DONE:**
  - On `tx_ready`=1: if `last_q`, then `grant`<=0, `ptr`<=g, go to IDLE.
  - Otherwise go to GRANTED.
- `ptr` updates only on packet release (normal or timeout).
- `timeout_err`: set by the watchdog, cleared by `clr_err`. Set takes priority if both occur in the same cycle.
- `req` bits of non-owners are ignored while granted. `req_data`/`req_last` of the owner are sampled only in GRANTED.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). A byte in flight is not re-sent.

## Timing
- `req` rising with the arbiter in IDLE and `tx_ready`=1: `grant` at edge +1, `transmitter_start`/`ack` at edge +2.
- `ack` is exactly one cycle wide, coincident with the first cycle `transmitter_start`=1.
- Per-byte overhead beyond transmitter busy time:
  - WAIT_DONE→GRANTED: 1 cycle.
  - GRANTED→start: 1 cycle.
- Packet release to next grant: 1 cycle (IDLE arbitration).
- Watchdog counts cycles in WAIT_BUSY; a timeout fires on the BUSY_TIMEOUT-th cycle after `transmitter_start` rose.
- No combinational path from inputs to outputs.

## Test plan
- Single requester: requester 0 sends 3 bytes 0x41,0x42,0x43 with `req_last` on the third; transmitter model holds busy 20 cycles. Required:
  - three `ack[0]` pulses;
  - `transmitter_data` sequence 0x41,0x42,0x43;
  - `grant` returns to 0 and `busy`=0 after the third `tx_ready` rise.
- Round-robin: requesters 0–3 each request a 1-byte packet simultaneously from reset. Required:
  - grant order 0,1,2,3;
  - repeating the simultaneous request then yields order 0,1,2,3 again (ptr=3 after serving 3).
- Packet lock: requester 1 owns a 4-byte packet and drops `req` for 10 cycles between bytes 2 and 3, while requester 2 requests. Required:
  - `grant` stays 0b0010 throughout;
  - requester 2 is granted only after requester 1's last byte completes.
- Watchdog: with BUSY_TIMEOUT=16, the transmitter model never drops `tx_ready`. Required:
  - `transmitter_start` high for exactly 16 cycles;
  - `timeout_err`=1 and `grant`=0;
  - `clr_err` pulse returns `timeout_err` to 0.
- Async reset in WAIT_DONE: assert `rst` mid-byte. Required:
  - all outputs 0 without waiting for a clock edge;
  - after release, a fresh request from requester 2 with requester 0 also requesting grants requester 0 first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared UART transmitter: locks one requester for a whole
// packet, forwards one byte per transmitter cycle and flags a transmitter that never goes busy.
module uart_tx_arbiter #(
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    input  logic        clr_err,
    input  logic        tx_ready,
    output logic [3:0]  grant,
    output logic [3:0]  ack,
    output logic [7:0]  transmitter_data,
    output logic        transmitter_start,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANTED   = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'(BUSY_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  ack_q, ack_d;
    logic [7:0]  data_q, data_d;
    logic        start_q, start_d;
    logic        err_q, err_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  owner_q, owner_d;
    logic [15:0] cnt_q, cnt_d;
    logic        found_s;
    logic [1:0]  pick_s;
    logic [1:0]  cand_s;

    // First requester after the pointer wins; the pointer itself is searched last.
    always_comb begin
        found_s = 1'b0;
        pick_s  = 2'd0;
        cand_s  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand_s = ptr_q + 2'(k);
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output computation for the packet FSM and watchdog.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_d   = 4'd0;
        data_d  = data_q;
        start_d = start_q;
        last_d  = last_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (tx_ready && found_s) begin
                    owner_d = pick_s;
                    grant_d = 4'b0001 << pick_s;
                    state_d = ST_GRANTED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANTED: begin
                // Owner may pause mid-packet; the grant is held regardless of other requests.
                if (req[owner_q] && tx_ready) begin
                    data_d  = req_data[{owner_q, 3'b000} +: 8];
                    start_d = 1'b1;
                    ack_d   = grant_q;
                    last_d  = req_last[owner_q];
                    cnt_d   = 16'd0;
                    state_d = ST_WAIT_BUSY;
                end else begin
                    state_d = ST_GRANTED;
                end
            end
            ST_WAIT_BUSY: begin
                if (!tx_ready) begin
                    start_d = 1'b0;
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    grant_d = 4'd0;
                    ptr_d   = owner_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready && last_q) begin
                    grant_d = 4'd0;
                    ptr_d   = owner_q;
                    state_d = ST_IDLE;
                end else if (tx_ready) begin
                    state_d = ST_GRANTED;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'd0;
                start_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 4'd0;
            ack_q   <= 4'd0;
            data_q  <= 8'h00;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= 2'd3;
            owner_q <= 2'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            start_q <= start_d;
            err_q   <= err_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant             = grant_q;
    assign ack               = ack_q;
    assign transmitter_data  = data_q;
    assign transmitter_start = start_q;
    assign busy              = busy_q;
    assign timeout_err       = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based requesters and a transmitter model driven at the
// falling edge, checked every cycle against a transaction-level reference of the arbitration rules.
module tb_uart_tx_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [31:0] req_data = 32'd0;
    logic [3:0]  req_last = 4'd0;
    logic        clr_err = 1'b0;
    logic        tx_ready = 1'b1;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [7:0]  transmitter_data;
    logic        transmitter_start;
    logic        busy;
    logic        timeout_err;

    uart_tx_arbiter #(.BUSY_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .clr_err(clr_err), .tx_ready(tx_ready), .grant(grant), .ack(ack),
        .transmitter_data(transmitter_data), .transmitter_start(transmitter_start),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // requester byte queues and pause control
    logic [7:0] bq [4][$];
    bit         lq [4][$];
    int         pause [4];
    int         pause_at [4];
    int         ackcnt [4];
    bit         rnd_pause = 0;
    bit         clr_req = 0;

    // transmitter model
    bit stuck = 0;
    int busy_min = 4, busy_max = 4, dly_max = 0;
    int tx_phase, tx_cnt;

    // reference model of the arbiter, in transaction terms
    bit         mon_en = 0;
    int         cyc = 0;
    int         m_owner, m_elig, m_rel, m_to, m_start_off;
    logic [1:0] m_ptr;
    bit         m_start, m_err, m_last;
    logic [3:0] exp_grant, exp_ack;

    int         run_cnt, last_run;
    int         grant_log[$];
    int         ack_log[$];
    logic [7:0] data_log[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [1:0] p, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(int'(p) + k) % 4]) return (int'(p) + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_init();
        m_owner = -1; m_elig = -1; m_rel = -1; m_to = -1; m_start_off = -1;
        m_ptr = 2'd3; m_start = 0; m_err = 0; m_last = 0;
        tx_phase = 0; tx_cnt = 0; run_cnt = 0; last_run = 0;
        for (int i = 0; i < 4; i++) begin
            pause[i] = 0; pause_at[i] = -1; ackcnt[i] = 0;
        end
    endtask

    task automatic tx_drop();
        tx_ready = 1'b0;
        tx_cnt = $urandom_range(busy_min, busy_max);
        tx_phase = 2;
        m_start_off = cyc + 1;
    endtask

    task automatic push_byte(input int i, input logic [7:0] d, input bit last);
        bq[i].push_back(d);
        lq[i].push_back(last);
    endtask

    // Falling edge: update reference, compare, then drive inputs for the next rising edge.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            cyc++;
            exp_ack = 4'd0;
            if (m_owner < 0) begin
                if (tx_ready && req != 4'd0) begin
                    m_owner = rr_pick(m_ptr, req);
                    m_elig = cyc + 1;
                    grant_log.push_back(m_owner);
                end
            end else if (cyc == m_rel) begin
                m_ptr = 2'(m_owner);
                m_owner = -1;
                m_rel = -1;
                m_elig = -1;
            end else if (m_elig >= 0 && cyc >= m_elig && req[m_owner] && tx_ready) begin
                exp_ack[m_owner] = 1'b1;
                m_elig = -1;
                m_start = 1;
                m_last = req_last[m_owner];
                if (stuck) begin
                    m_start_off = cyc + TO; m_rel = cyc + TO; m_to = cyc + TO;
                end
            end
            if (cyc == m_to) m_err = 1;
            else if (clr_err) m_err = 0;
            if (cyc == m_start_off) m_start = 0;
            exp_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;

            check_eq("grant", grant, exp_grant);
            check_eq("ack", ack, exp_ack);
            check_eq("start", transmitter_start, m_start);
            check_eq("busy", busy, m_owner >= 0);
            check_eq("timeout_err", timeout_err, m_err);

            for (int i = 0; i < 4; i++) begin
                if (ack[i]) begin
                    ack_log.push_back(i);
                    if (bq[i].size() > 0) begin
                        check_eq("data", transmitter_data, bq[i][0]);
                        data_log.push_back(transmitter_data);
                        void'(bq[i].pop_front());
                        void'(lq[i].pop_front());
                        ackcnt[i]++;
                        if (ackcnt[i] == pause_at[i]) pause[i] = 10;
                        else if (rnd_pause && $urandom_range(0, 3) == 0) pause[i] = $urandom_range(1, 5);
                    end
                end
            end

            if (transmitter_start) run_cnt++;
            else if (run_cnt > 0) begin
                last_run = run_cnt; run_cnt = 0;
            end

            case (tx_phase)
                0: if (transmitter_start && !stuck && tx_ready) begin
                    tx_cnt = $urandom_range(0, dly_max);
                    if (tx_cnt == 0) tx_drop();
                    else tx_phase = 1;
                end
                1: begin
                    tx_cnt--;
                    if (tx_cnt == 0) tx_drop();
                end
                default: begin
                    tx_cnt--;
                    if (tx_cnt <= 0) begin
                        tx_ready = 1'b1;
                        tx_phase = 0;
                        if (m_last) m_rel = cyc + 1;
                        else m_elig = cyc + 2;
                    end
                end
            endcase

            for (int i = 0; i < 4; i++) begin
                req[i] = (bq[i].size() > 0) && (pause[i] == 0);
                if (pause[i] > 0) pause[i]--;
                req_data[8*i +: 8] = (bq[i].size() > 0) ? bq[i][0] : 8'h00;
                req_last[i] = (bq[i].size() > 0) ? lq[i][0] : 1'b0;
            end
            clr_err = clr_req;
            clr_req = 0;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_grant"}, grant, 4'd0);
        check_eq({tag, "_ack"}, ack, 4'd0);
        check_eq({tag, "_data"}, transmitter_data, 8'h00);
        check_eq({tag, "_start"}, transmitter_start, 1'b0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_err"}, timeout_err, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        mon_en = 0;
        #1;
        check_outputs_zero(tag);
        for (int i = 0; i < 4; i++) begin
            bq[i].delete(); lq[i].delete();
        end
        req = 4'd0; req_data = 32'd0; req_last = 4'd0;
        clr_err = 1'b0; clr_req = 0; tx_ready = 1'b1; stuck = 0;
        model_init();
        @(posedge clk);
        #2;
        rst = 1'b0;
        mon_en = 1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done;
        done = 0;
        for (int n = 0; n < budget && !done; n++) begin
            @(posedge clk);
            #1;
            done = bq[0].size() == 0 && bq[1].size() == 0 && bq[2].size() == 0 &&
                   bq[3].size() == 0 && m_owner < 0 && tx_phase == 0 && grant == 4'd0;
        end
        check_eq(tag, done, 1'b1);
    endtask

    task automatic clear_logs();
        grant_log.delete(); ack_log.delete(); data_log.delete();
        for (int i = 0; i < 4; i++) ackcnt[i] = 0;
    endtask

    initial begin
        int got;
        int pushed;
        bit ok;
        logic [7:0] exp_bytes [3];
        model_init();
        #1 rst = 1'b1;
        #1 check_outputs_zero("por");
        @(posedge clk);
        #2 rst = 1'b0;
        mon_en = 1;

        // single requester, three-byte packet, long transmitter busy time
        busy_min = 20; busy_max = 20; dly_max = 0;
        clear_logs();
        @(posedge clk); #1;
        push_byte(0, 8'h41, 0); push_byte(0, 8'h42, 0); push_byte(0, 8'h43, 1);
        wait_idle("single_done", 400);
        check_eq("single_acks", ack_log.size(), 3);
        exp_bytes[0] = 8'h41; exp_bytes[1] = 8'h42; exp_bytes[2] = 8'h43;
        for (int j = 0; j < 3; j++) begin
            got = (j < data_log.size()) ? int'(data_log[j]) : -1;
            check_eq("single_byte", got, exp_bytes[j]);
        end
        check_eq("single_grant", grant, 4'd0);
        check_eq("single_busy", busy, 1'b0);

        // round robin from reset, twice
        do_reset("rr_rst");
        busy_min = 2; busy_max = 2; dly_max = 1;
        for (int rep = 0; rep < 2; rep++) begin
            clear_logs();
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) push_byte(i, 8'(8'hA0 + i), 1);
            wait_idle("rr_done", 300);
            check_eq("rr_count", grant_log.size(), 4);
            for (int k = 0; k < 4; k++) begin
                got = (k < grant_log.size()) ? grant_log[k] : -1;
                check_eq("rr_order", got, k);
            end
        end

        // packet lock: owner pauses between bytes 2 and 3 while another requests
        busy_min = 3; busy_max = 3; dly_max = 0;
        clear_logs();
        pause_at[1] = 2;
        @(posedge clk); #1;
        for (int b = 0; b < 4; b++) push_byte(1, 8'(8'h10 + b), b == 3);
        ok = 0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(posedge clk); #1;
            ok = (grant == 4'b0010);
        end
        check_eq("lock_grant1", ok, 1'b1);
        push_byte(2, 8'h77, 1);
        wait_idle("lock_done", 400);
        pause_at[1] = -1;
        check_eq("lock_grants", grant_log.size(), 2);
        for (int k = 0; k < 5; k++) begin
            got = (k < ack_log.size()) ? ack_log[k] : -1;
            check_eq("lock_ack_order", got, (k < 4) ? 1 : 2);
        end

        // watchdog: transmitter never goes busy
        clear_logs();
        stuck = 1;
        @(posedge clk); #1;
        push_byte(3, 8'h5A, 1);
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(posedge clk); #1;
            ok = (timeout_err == 1'b1);
        end
        check_eq("wd_fired", ok, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check_eq("wd_start_len", last_run, TO);
        check_eq("wd_err", timeout_err, 1'b1);
        check_eq("wd_grant", grant, 4'd0);
        check_eq("wd_acks", ack_log.size(), 1);
        stuck = 0;
        clr_req = 1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("wd_clr", timeout_err, 1'b0);

        // asynchronous reset while waiting for the transmitter to finish a byte
        busy_min = 20; busy_max = 20; dly_max = 0;
        clear_logs();
        @(posedge clk); #1;
        push_byte(2, 8'h31, 0); push_byte(2, 8'h32, 1);
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(posedge clk); #1;
            ok = (tx_phase == 2) && (transmitter_start == 1'b0) && (grant == 4'b0100) && (tx_cnt > 5);
        end
        check_eq("ar_reach", ok, 1'b1);
        do_reset("ar_rst");
        busy_min = 2; busy_max = 4; dly_max = 2;
        clear_logs();
        @(posedge clk); #1;
        push_byte(2, 8'h22, 1); push_byte(0, 8'h00, 1);
        wait_idle("ar_done", 300);
        got = (grant_log.size() > 0) ? grant_log[0] : -1;
        check_eq("ar_first", got, 0);
        got = (grant_log.size() > 1) ? grant_log[1] : -1;
        check_eq("ar_second", got, 2);

        // randomized traffic
        busy_min = 1; busy_max = 6; dly_max = 3; rnd_pause = 1;
        clear_logs();
        pushed = 0;
        for (int it = 0; it < 300; it++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0) begin
                int r, len;
                r = $urandom_range(0, 3);
                len = $urandom_range(1, 4);
                if (bq[r].size() < 6) begin
                    for (int b = 0; b < len; b++) push_byte(r, 8'($urandom), b == len - 1);
                    pushed += len;
                end
            end
        end
        wait_idle("rand_done", 8000);
        check_eq("rand_bytes", ack_log.size(), pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
